vga_timing: RTL and testbench
=============================

// Module: vga_timing
// PURPOSE
//  Raster timing generator and VGA output stage for 640x480@60.
//  - Drives hdata/vdata into the head of the layer chain.
//  - Registers the final composited RGB from the tail of the chain onto the VGA pins.
//  - Delays hsync/vsync/blank so that they stay aligned with the layer pipeline.
//  - Runs on the 100 MHz system clock using an internal pixel-tick divider.
// PARAMETERS
//  DEPTH   4    bits per colour channel
//  HWIDTH  12   hdata width
//  VWIDTH  12   vdata width
//  CLKDIV  4    clk cycles per pixel tick (>=2; leaves >=1 clk for the vram read)
//  PIPE    1    pixel ticks from counter value to VGA pins (>=1)
//  H_VIS 640, H_FP 16, H_SYNC 96, H_BP 48   horizontal timing, in pixels
//  V_VIS 480, V_FP 10, V_SYNC 2,  V_BP 33   vertical timing, in lines
// PORTS
//  clk          in   1       system clock
//  rst_n        in   1       synchronous active-low reset
//  R_in         in   DEPTH   composited red from the last layer
//  G_in         in   DEPTH   composited green from the last layer
//  B_in         in   DEPTH   composited blue from the last layer
//  hdata        out  HWIDTH  current horizontal counter, 0..H_TOT-1
//  vdata        out  VWIDTH  current vertical counter, 0..V_TOT-1
//  pix_tick     out  1       1-clk strobe; the counters advance on this clk edge
//  active       out  1       counters are in the visible region (h<H_VIS && v<V_VIS)
//  frame_start  out  1       1-clk pulse on the tick where the counters wrap to (0,0)
//  vga_r        out  DEPTH   registered pixel red
//  vga_g        out  DEPTH   registered pixel green
//  vga_b        out  DEPTH   registered pixel blue
//  vga_hs       out  1       hsync, active-low
//  vga_vs       out  1       vsync, active-low
// BEHAVIOUR
//  Derived totals
//  - H_TOT = H_VIS+H_FP+H_SYNC+H_BP = 800.
//  - V_TOT = V_VIS+V_FP+V_SYNC+V_BP = 525.
//  Reset (rst_n=0 at a clk edge)
//  - Divider, hdata and vdata go to 0.
//  - pix_tick, frame_start, vga_r/g/b and the delay line go to 0.
//  - active reads 1, since it decodes counters (0,0).
//  - vga_hs and vga_vs go to 1 (deasserted).
//  - Reset mid-frame restarts at (0,0) with no partial-tick carry-over.
//  Divider
//  - div counts 0..CLKDIV-1 and wraps.
//  - pix_tick = (div==CLKDIV-1), registered.
//  - The first pix_tick is the CLKDIV-th clk after rst_n rises.
//  Counters (update only on clk edges where pix_tick=1)
//  - hdata increments; at H_TOT-1 it wraps to 0 and vdata increments.
//  - vdata wraps from V_TOT-1 to 0 when hdata also wraps.
//  - hdata/vdata stay stable for CLKDIV clks. The layer vram read (1 clk) completes within that window.
//  frame_start
//  - High for exactly the clk in which the counters read (0,0) after a wrap.
//  - Never high out of reset.
//  Sync decode (combinational from the counters)
//  - hs_raw = !(H_VIS+H_FP <= h < H_VIS+H_FP+H_SYNC), i.e. low for h in 656..751.
//  - vs_raw low for v in 490..491.
//  - act_raw = active.
//  Delay line
//  - PIPE-1 tick-enabled stages carry {act,hs,vs}.
//  - Pixel (h,v) appears on all VGA pins together, PIPE ticks after the counters first show (h,v).
//  - At the tick edge that emits pixel (h,v): vga_r/g/b <= act ? {R_in,G_in,B_in} : 0, and vga_hs/vga_vs <= the delayed hs/vs.
//  - R_in/G_in/B_in are sampled only at tick edges. Between ticks the outputs hold.
//  - In blanking, RGB is forced to 0 regardless of R_in/G_in/B_in.
//  Widths
//  - Counters are unsigned at HWIDTH/VWIDTH bits.
//  - Elaboration fails if H_TOT >= 2**HWIDTH or V_TOT >= 2**VWIDTH.
// TESTING
//  1. Reset then release, CLKDIV=4: first pix_tick at clk 4 -> hdata 0->1; vga_hs=vga_vs=1; RGB=0.
//  2. Run one line: hdata reaches 799 then 0; vdata 0->1; vga_hs low for exactly 96 ticks, starting with pixel h=656 (PIPE=1).
//  3. Run a full frame: 420000 ticks. frame_start pulses once per frame on the tick that produces (0,0). vga_vs low for lines 490-491 (1600 ticks).
//  4. R_in=G_in=B_in=4'hF constant: vga_r=F for pixels 0..639 of lines 0..479; vga_r=0 at h=640..799 and for all of lines 480..524.
//  5. PIPE=2, R_in ramping by pixel: RGB for (h,v) and its sync/blank both appear 2 ticks after hdata=h; no one-tick skew.
//  6. Assert rst_n=0 for one clk at (h=300, v=200): next clk shows hdata=vdata=0 and vga_hs=vga_vs=1; timing then repeats exactly as in test 1.

Source files
------------

// File: rtl/vga_timing.sv
// Raster timing generator and VGA output stage.
// Pixel-tick divider, h/v counters, sync decode, aligned pin registers.
module vga_timing #(
  parameter int DEPTH  = 4,
  parameter int HWIDTH = 12,
  parameter int VWIDTH = 12,
  parameter int CLKDIV = 4,
  parameter int PIPE   = 1,
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DEPTH-1:0]  R_in,
  input  logic [DEPTH-1:0]  G_in,
  input  logic [DEPTH-1:0]  B_in,
  output logic [HWIDTH-1:0] hdata,
  output logic [VWIDTH-1:0] vdata,
  output logic              pix_tick,
  output logic              active,
  output logic              frame_start,
  output logic [DEPTH-1:0]  vga_r,
  output logic [DEPTH-1:0]  vga_g,
  output logic [DEPTH-1:0]  vga_b,
  output logic              vga_hs,
  output logic              vga_vs
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int HS0   = H_VIS + H_FP;
  localparam int HS1   = H_VIS + H_FP + H_SYNC;
  localparam int VS0   = V_VIS + V_FP;
  localparam int VS1   = V_VIS + V_FP + V_SYNC;
  localparam int DW    = $clog2(CLKDIV);

  generate
    if (H_TOT >= 2**HWIDTH) begin : g_hchk
      $error("vga_timing: H_TOT does not fit in HWIDTH");
    end
    if (V_TOT >= 2**VWIDTH) begin : g_vchk
      $error("vga_timing: V_TOT does not fit in VWIDTH");
    end
    if (CLKDIV < 2) begin : g_dchk
      $error("vga_timing: CLKDIV must be >= 2");
    end
    if (PIPE < 1) begin : g_pchk
      $error("vga_timing: PIPE must be >= 1");
    end
  endgenerate

  logic [DW-1:0] div;
  logic          h_end;
  logic          v_end;
  logic          hs_on;
  logic          vs_on;
  logic [2:0]    raw;
  logic [2:0]    tap;

  assign h_end = (hdata == HWIDTH'(H_TOT - 1));
  assign v_end = (vdata == VWIDTH'(V_TOT - 1));

  // Divider; pix_tick is registered one clk ahead so it is high while div is at its top.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div      <= '0;
      pix_tick <= 1'b0;
    end else begin
      div      <= (div == DW'(CLKDIV - 1)) ? '0 : div + 1'b1;
      pix_tick <= (div == DW'(CLKDIV - 2));
    end
  end

  // Raster counters and frame-start pulse, advancing on tick edges.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hdata       <= '0;
      vdata       <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= pix_tick & h_end & v_end;
      if (pix_tick) begin
        hdata <= h_end ? '0 : hdata + 1'b1;
        if (h_end)
          vdata <= v_end ? '0 : vdata + 1'b1;
      end
    end
  end

  // Visible-region and sync decode; syncs kept active-high internally.
  always_comb begin
    active = (hdata < HWIDTH'(H_VIS)) && (vdata < VWIDTH'(V_VIS));
    hs_on  = (hdata >= HWIDTH'(HS0)) && (hdata < HWIDTH'(HS1));
    vs_on  = (vdata >= VWIDTH'(VS0)) && (vdata < VWIDTH'(VS1));
    raw    = {active, hs_on, vs_on};
  end

  generate
    if (PIPE == 1) begin : g_nodly
      assign tap = raw;
    end else begin : g_dly
      logic [2:0] sr [PIPE-1];
      // Tick-enabled delay of {act,hs,vs}; zero reset means blank, no sync.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int i = 0; i < PIPE - 1; i++)
            sr[i] <= 3'b000;
        end else if (pix_tick) begin
          sr[0] <= raw;
          for (int i = 1; i < PIPE - 1; i++)
            sr[i] <= sr[i-1];
        end
      end
      assign tap = sr[PIPE-2];
    end
  endgenerate

  // Pin registers: colour gated by blanking, syncs converted to active-low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vga_r  <= '0;
      vga_g  <= '0;
      vga_b  <= '0;
      vga_hs <= 1'b1;
      vga_vs <= 1'b1;
    end else if (pix_tick) begin
      vga_r  <= tap[2] ? R_in : '0;
      vga_g  <= tap[2] ? G_in : '0;
      vga_b  <= tap[2] ? B_in : '0;
      vga_hs <= ~tap[1];
      vga_vs <= ~tap[0];
    end
  end

endmodule

// File: tb/tb_vga_timing.sv
// Self-checking bench for vga_timing: PIPE=1 and PIPE=2 instances
// on a reduced raster, random colour input, arithmetic raster model.
module tb_vga_timing;

  localparam int DIV = 4;
  localparam int HV = 20, HF = 2, HSY = 4, HB = 3;
  localparam int VV = 6,  VF = 1, VSY = 2, VB = 2;
  localparam int HT = HV + HF + HSY + HB;
  localparam int VT = VV + VF + VSY + VB;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] r_in = '0, g_in = '0, b_in = '0;

  logic [11:0] h1, v1, h2, v2;
  logic pt1, act1, fs1, hs1, vs1;
  logic pt2, act2, fs2, hs2, vs2;
  logic [3:0] r1, g1, b1, r2, g2, b2;

  int tests = 0;
  int fails = 0;
  int c = 0;
  int k;
  logic [11:0] rgb_at [2048];

  always #5 clk = ~clk;

  vga_timing #(
    .CLKDIV(DIV), .PIPE(1),
    .H_VIS(HV), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB)
  ) dut1 (
    .clk(clk), .rst_n(rst_n),
    .R_in(r_in), .G_in(g_in), .B_in(b_in),
    .hdata(h1), .vdata(v1), .pix_tick(pt1),
    .active(act1), .frame_start(fs1),
    .vga_r(r1), .vga_g(g1), .vga_b(b1),
    .vga_hs(hs1), .vga_vs(vs1)
  );

  vga_timing #(
    .CLKDIV(DIV), .PIPE(2),
    .H_VIS(HV), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB)
  ) dut2 (
    .clk(clk), .rst_n(rst_n),
    .R_in(r_in), .G_in(g_in), .B_in(b_in),
    .hdata(h2), .vdata(v2), .pix_tick(pt2),
    .active(act2), .frame_start(fs2),
    .vga_r(r2), .vga_g(g2), .vga_b(b2),
    .vga_hs(hs2), .vga_vs(vs2)
  );

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s c=%0d observed=%0d expected=%0d", tag, c, obs, exp);
    end
  endtask

  task automatic check_pins(input int p, input int rgb,
                            input int hs, input int vs);
    int j, hj, vj, a, eh, ev, er;
    j = k - p;
    if (j < 0) begin
      er = 0; eh = 1; ev = 1;
    end else begin
      hj = j % HT;
      vj = (j / HT) % VT;
      a  = (hj < HV && vj < VV) ? 1 : 0;
      eh = (hj >= HV + HF && hj < HV + HF + HSY) ? 0 : 1;
      ev = (vj >= VV + VF && vj < VV + VF + VSY) ? 0 : 1;
      er = a ? int'(rgb_at[k]) : 0;
    end
    check($sformatf("rgb_p%0d", p), rgb, er);
    check($sformatf("hs_p%0d", p), hs, eh);
    check($sformatf("vs_p%0d", p), vs, ev);
  endtask

  task automatic step(input int n);
    int eh, ev, tick;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      if (!rst_n) c = 0;
      else c++;
      k = c / DIV;
      tick = (c > 0 && c % DIV == 0) ? 1 : 0;
      if (tick) rgb_at[k] = {r_in, g_in, b_in};
      #1;
      eh = k % HT;
      ev = (k / HT) % VT;
      check("pix_tick", int'(pt1), (c % DIV == DIV - 1) ? 1 : 0);
      check("pix_tick2", int'(pt2), (c % DIV == DIV - 1) ? 1 : 0);
      check("hdata", int'(h1), eh);
      check("vdata", int'(v1), ev);
      check("hdata2", int'(h2), eh);
      check("vdata2", int'(v2), ev);
      check("active", int'(act1), (eh < HV && ev < VV) ? 1 : 0);
      check("active2", int'(act2), (eh < HV && ev < VV) ? 1 : 0);
      check("frame_start", int'(fs1),
            (tick && k % (HT * VT) == 0) ? 1 : 0);
      check("frame_start2", int'(fs2),
            (tick && k % (HT * VT) == 0) ? 1 : 0);
      check_pins(1, int'({r1, g1, b1}), int'(hs1), int'(vs1));
      check_pins(2, int'({r2, g2, b2}), int'(hs2), int'(vs2));
      {r_in, g_in, b_in} = 12'($urandom);
    end
  endtask

  initial begin
    {r_in, g_in, b_in} = 12'hFFF;
    rst_n = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(DIV * (HT * VT * 2 + 60));
    step($urandom_range(1, 200));
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(DIV * (HT * VT + HT + 10));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
